// File: rtl/id_sb_pkg.sv
// rtl/id_sb_pkg.sv - shared types and helpers for the ID-stage scoreboard
package id_sb_pkg;

  // Entry rd is stored zero-extended to this width; REG_ADDR_W must not exceed it.
  localparam int SB_RD_MAX_W = 8;
  localparam logic [SB_RD_MAX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   valid;
    logic [SB_RD_MAX_W-1:0] rd;
    logic                   reg_write;
    logic                   is_load;
  } sb_entry_t;

  function automatic int sb_sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/id_sb_src_lookup.sv
// rtl/id_sb_src_lookup.sv - per-source-port forward/regfile/stall resolution
module id_sb_src_lookup
  import id_sb_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 2,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 2
) (
  input  sb_entry_t [NUM_STAGES-1:0]   entries,
  input  logic [REG_ADDR_W-1:0]        src_addr,
  input  logic                         src_used,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic [SEL_W-1:0]             fwd_sel,
  output logic [DATA_W-1:0]            src_data,
  output logic                         stall_req
);

  logic [SB_RD_MAX_W-1:0] addr_ext;
  logic                   hit;
  logic                   hit_ready;
  logic [SEL_W-1:0]       hit_sel;
  logic [DATA_W-1:0]      hit_data;

  assign addr_ext = SB_RD_MAX_W'(src_addr);

  // Scan oldest to youngest so the youngest live match is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_sel   = '0;
    hit_data  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].reg_write &&
          entries[k].rd != REG_ZERO && entries[k].rd == addr_ext) begin
        hit       = 1'b1;
        hit_ready = !entries[k].is_load || (k >= LOAD_LAT - 1);
        hit_sel   = SEL_W'(k + 1);
        hit_data  = stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    fwd_sel   = '0;
    src_data  = rf_data;
    stall_req = 1'b0;
    if (src_used && addr_ext != REG_ZERO && hit) begin
      if (hit_ready) begin
        fwd_sel  = hit_sel;
        src_data = hit_data;
      end else begin
        stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - ID-stage in-flight writer record, forwarding and load-use stall
// Optional counters: define ID_SCOREBOARD_STATS_EN.
module id_scoreboard
  import id_sb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 2,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = sb_sel_width(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic                          issue_reg_write,
  input  logic                          issue_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic [NUM_SRC*DATA_W-1:0]     rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0]  stage_data,
  input  logic                          flush,
  output logic                          stall,
  output logic                          pc_if_id_write,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]     src_data
`ifdef ID_SCOREBOARD_STATS_EN
  ,
  input  logic                          stat_clear,
  output logic [31:0]                   stat_stall_cycles,
  output logic [31:0]                   stat_fwd_count
`endif
);

  sb_entry_t [NUM_STAGES-1:0] entries;
  sb_entry_t                  issue_entry;
  logic [NUM_SRC-1:0]         stall_req;

  // A stalled ID instruction enters as a bubble; it will be re-presented next cycle.
  always_comb begin
    issue_entry.valid     = issue_valid && !stall;
    issue_entry.rd        = SB_RD_MAX_W'(issue_rd);
    issue_entry.reg_write = issue_reg_write;
    issue_entry.is_load   = issue_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else if (flush) begin
      entries <= '0;
    end else begin
      entries[0] <= issue_entry;
      for (int k = 1; k < NUM_STAGES; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    id_sb_src_lookup #(
      .NUM_STAGES (NUM_STAGES),
      .LOAD_LAT   (LOAD_LAT),
      .REG_ADDR_W (REG_ADDR_W),
      .DATA_W     (DATA_W),
      .SEL_W      (SEL_W)
    ) u_lookup (
      .entries    (entries),
      .src_addr   (src_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .src_used   (src_used[g]),
      .rf_data    (rf_data[g*DATA_W +: DATA_W]),
      .stage_data (stage_data),
      .fwd_sel    (fwd_sel[g*SEL_W +: SEL_W]),
      .src_data   (src_data[g*DATA_W +: DATA_W]),
      .stall_req  (stall_req[g])
    );
  end

  assign stall          = issue_valid && (|stall_req);
  assign pc_if_id_write = !stall;

`ifdef ID_SCOREBOARD_STATS_EN
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_sel[i*SEL_W +: SEL_W] != '0) fwd_inc = fwd_inc + 32'd1;
    end
  end

  assign fwd_sum = {1'b0, stat_fwd_count} + {1'b0, fwd_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_fwd_count    <= '0;
    end else if (stat_clear) begin
      stat_stall_cycles <= '0;
      stat_fwd_count    <= '0;
    end else begin
      if (stall && stat_stall_cycles != 32'hFFFF_FFFF)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (issue_valid && !stall)
        stat_fwd_count <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed self-checking bench for id_scoreboard
// Also exercises the counters when ID_SCOREBOARD_STATS_EN is defined.
module tb_id_scoreboard;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_reg_write;
  logic        issue_is_load;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic        flush;
  logic        stall;
  logic        pc_if_id_write;
  logic [3:0]  fwd_sel;
  logic [63:0] src_data;
`ifdef ID_SCOREBOARD_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_fwd_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_reg_write (issue_reg_write),
    .issue_is_load   (issue_is_load),
    .src_addr        (src_addr),
    .src_used        (src_used),
    .rf_data         (rf_data),
    .stage_data      (stage_data),
    .flush           (flush),
    .stall           (stall),
    .pc_if_id_write  (pc_if_id_write),
    .fwd_sel         (fwd_sel),
    .src_data        (src_data)
`ifdef ID_SCOREBOARD_STATS_EN
    ,
    .stat_clear        (stat_clear),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_fwd_count    (stat_fwd_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic rw, input logic ld);
    issue_valid     = v;
    issue_rd        = rd;
    issue_reg_write = rw;
    issue_is_load   = ld;
  endtask

  task automatic set_src(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
    src_addr = {a1, a0};
    src_used = used;
  endtask

  task automatic drain();
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(5'd0, 5'd0, 2'b00);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
`ifdef ID_SCOREBOARD_STATS_EN
    stat_clear = 1'b0;
`endif
    rf_data    = {RF1, RF0};
    stage_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    set_issue(1'b1, 5'd8, 1'b1, 1'b1);
    set_src(5'd8, 5'd9, 2'b11);
    #1;
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_pcw", pc_if_id_write, 1'b1);
    check_eq("rst_fwd", fwd_sel, 4'h0);
    check_eq("rst_data", src_data, {RF1, RF0});
    tick();
    rst_n = 1'b1;
    drain();

    // ALU back-to-back
    set_issue(1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd11, 1'b1, 1'b0);
    set_src(5'd8, 5'd0, 2'b01);
    stage_data[31:0] = 32'h0000_1234;
    #1;
    check_eq("alu_stall", stall, 1'b0);
    check_eq("alu_fwd", fwd_sel, 4'h1);
    check_eq("alu_data", src_data, {RF1, 32'h0000_1234});
    drain();

    // Load-use: one stall cycle, then forward from entry 1
    set_issue(1'b1, 5'd9, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd12, 1'b1, 1'b0);
    set_src(5'd0, 5'd9, 2'b10);
    stage_data[63:32] = 32'hDEAD_BEEF;
    #1;
    check_eq("lu_stall", stall, 1'b1);
    check_eq("lu_pcw", pc_if_id_write, 1'b0);
    tick();
    check_eq("lu_stall2", stall, 1'b0);
    check_eq("lu_fwd", fwd_sel, 4'h8);
    check_eq("lu_data", src_data[63:32], 32'hDEAD_BEEF);
    drain();

    // Youngest match wins
    stage_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    set_issue(1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(5'd10, 5'd0, 2'b11);
    #1;
    check_eq("young_fwd", fwd_sel, 4'h1);
    check_eq("young_data", src_data, {RF1, 32'h0000_000A});
    tick();
    check_eq("older_fwd", fwd_sel, 4'h2);
    check_eq("older_data", src_data[31:0], 32'h0000_000B);
    drain();

    // Flush while stalled on a load-use
    set_issue(1'b1, 5'd9, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd13, 1'b1, 1'b0);
    set_src(5'd0, 5'd9, 2'b10);
    #1;
    check_eq("fl_pre_stall", stall, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_stall", stall, 1'b0);
    check_eq("fl_fwd", fwd_sel, 4'h0);
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    set_src(5'd13, 5'd9, 2'b11);
    #1;
    check_eq("fl_not_rec", fwd_sel, 4'h0);
    drain();

    // src_used masking and issue_valid gating
    set_issue(1'b1, 5'd9, 1'b1, 1'b1);
    tick();
    set_issue(1'b1, 5'd14, 1'b1, 1'b0);
    set_src(5'd0, 5'd9, 2'b00);
    #1;
    check_eq("mask_stall", stall, 1'b0);
    set_src(5'd0, 5'd9, 2'b10);
    #1;
    check_eq("unmask_stall", stall, 1'b1);
    issue_valid = 1'b0;
    #1;
    check_eq("noissue_stall", stall, 1'b0);
    drain();

    // Register 0 is never tracked
    set_issue(1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(5'd0, 5'd0, 2'b11);
    #1;
    check_eq("r0_fwd", fwd_sel, 4'h0);
    check_eq("r0_data", src_data, {RF1, RF0});
    drain();

    // Asynchronous reset with three live entries
    set_issue(1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    set_issue(1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    set_src(5'd8, 5'd10, 2'b11);
    #1;
    check_eq("mid_fwd", fwd_sel, 4'h7);
    check_eq("mid_data", src_data, {32'h0000_000A, 32'h0000_000C});
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_stall", stall, 1'b0);
    check_eq("arst_fwd", fwd_sel, 4'h0);
    check_eq("arst_data", src_data, {RF1, RF0});
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_fwd", fwd_sel, 4'h0);

`ifdef ID_SCOREBOARD_STATS_EN
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check_eq("st_clr_stall", stat_stall_cycles, 32'd0);
    check_eq("st_clr_fwd", stat_fwd_count, 32'd0);
    set_issue(1'b1, 5'd9, 1'b1, 1'b1);
    set_src(5'd0, 5'd0, 2'b00);
    tick();
    set_issue(1'b1, 5'd12, 1'b1, 1'b0);
    set_src(5'd0, 5'd9, 2'b10);
    tick();
    check_eq("st_stall1", stat_stall_cycles, 32'd1);
    check_eq("st_fwd0", stat_fwd_count, 32'd0);
    tick();
    check_eq("st_stall_hold", stat_stall_cycles, 32'd1);
    check_eq("st_fwd1", stat_fwd_count, 32'd1);
    set_issue(1'b0, 5'd0, 1'b0, 1'b0);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check_eq("st_clr2_stall", stat_stall_cycles, 32'd0);
    check_eq("st_clr2_fwd", stat_fwd_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised successor to the ID-stage load-use detector and ID forwarder.
- Keeps its own shift-register record of in-flight writers, one entry per downstream stage.
- Per source operand, resolves one of: forward from a stage, read the register file, or stall.
- Configurable source-port count, forwarding depth and load latency. Sits in ID, drives the PC/IF_ID write enable and the operands for branch compare, JR and ID_EX.

Parameters:
- NUM_SRC, 2, number of source operand ports (rs, rt, ...)
- NUM_STAGES, 3, tracked downstream stages; entry k = issued k+1 cycles ago (0=EX, 1=MEM, 2=WB)
- LOAD_LAT, 2, load data valid from entry LOAD_LAT-1 onward; range 1..NUM_STAGES
- REG_ADDR_W, 5, register address width
- DATA_W, 32, operand width
- SEL_W, $clog2(NUM_STAGES+1), forward-select width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  ID holds a valid instruction
- issue_rd  in  REG_ADDR_W  destination register of the ID instruction
- issue_reg_write  in  1  ID instruction writes a register
- issue_is_load  in  1  ID instruction is a load
- src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses, port i at [i*REG_ADDR_W +: REG_ADDR_W]
- src_used  in  NUM_SRC  port i is actually read by this instruction
- rf_data  in  NUM_SRC*DATA_W  register-file read data per port
- stage_data  in  NUM_STAGES*DATA_W  result data of entry k
- flush  in  1  interrupt/exception: kill all in-flight entries
- stall  out  1  hold PC and IF_ID, inject bubble
- pc_if_id_write  out  1  equals ~stall
- fwd_sel  out  NUM_SRC*SEL_W  0 = regfile, k+1 = entry k
- src_data  out  NUM_SRC*DATA_W  resolved operand per port

Behaviour:
- Entry fields: valid, rd, reg_write, is_load. An entry is live when valid && reg_write && rd != 0.
- Reset: all entries invalid; stall=0, pc_if_id_write=1, fwd_sel=0, src_data=rf_data. Reset is asynchronous and effective mid-operation.
- Each posedge:
  - entry k+1 <= entry k.
  - Entry 0 <= issue fields when issue_valid && ~stall; otherwise a bubble (valid=0).
  - Entry NUM_STAGES-1 is dropped; its regfile write completes on that edge.
- flush=1: every entry is invalid after the edge. Flush wins over a simultaneous issue; the issue is dropped.
- Lookup for port i, evaluated only when src_used[i] && src_addr != 0:
  - Select the youngest live entry k (lowest k) with rd == src_addr.
  - Ready when ~is_load, or when is_load && k >= LOAD_LAT-1.
  - Ready: fwd_sel = k+1, src_data = stage_data[k].
  - Not ready: stall request for that port.
  - No match: fwd_sel = 0, src_data = rf_data.
- Youngest-match rule holds even if an older entry is ready. The newest value always wins; the older value is never forwarded.
- stall = issue_valid && OR of the per-port stall requests. It is purely combinational from the entries and the inputs, with no cycle of latency.
- While stalled, fwd_sel and src_data still reflect the lookup (don't-care to consumers).
- Register 0 is never tracked and never forwarded.
- With LOAD_LAT=2 and the defaults, a dependent instruction immediately after a load gets one stall cycle, then forwards from MEM (entry 1).

Optional Feature:
- Macro: ID_SCOREBOARD_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles[31:0] and stat_fwd_count[31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - stat_stall_cycles increments each cycle stall=1.
  - stat_fwd_count increments by the number of ports with fwd_sel != 0 in cycles where issue_valid && ~stall.
  - Adds input stat_clear, which synchronously zeroes both counters. stat_clear has priority over increment.
- Undefined: no counters and no stat ports; all other behaviour is identical.

Decomposition:
- Package id_sb_pkg holds:
  - the sb_entry_t struct (valid, rd, reg_write, is_load);
  - the function computing SEL_W;
  - the constant REG_ZERO = 0.
- Sub-module id_sb_src_lookup, instantiated NUM_SRC times:
  - inputs: the entry vector, src_addr, src_used, rf_data, stage_data;
  - outputs: fwd_sel, src_data, stall_req.
- The top level holds the entry shift register, flush, stall OR-reduction and the optional counters.

Test Plan:
- Reset mid-stream: rst_n low with 3 live entries -> stall=0, fwd_sel=0, src_data=rf_data immediately; no forwarding after release until a new issue.
- ALU back-to-back: issue add $8 (reg_write=1); next cycle src0=$8 with stage_data[0]=32'h1234 -> stall=0, fwd_sel[0]=1, src_data[0]=32'h1234.
- Load-use: issue lw $9; next cycle src1=$9, src_used=2'b10 -> stall=1 for exactly 1 cycle. Next cycle fwd_sel[1]=2, src_data[1]=stage_data[1]=32'hDEAD_BEEF.
- Youngest wins: $10 written at entries 0 and 2 (stage_data 32'hA and 32'hC) -> fwd_sel=1, src_data=32'hA. src_addr=0 -> fwd_sel=0.
- Flush with stalled load-use: flush=1 while stall=1 -> next cycle stall=0, fwd_sel=0; the ID instruction is not recorded.
- src_used masking: src1=$9 hits a pending load with src_used[1]=0 -> stall=0. With ID_SCOREBOARD_STATS_EN, counters match the stall/forward events and stat_clear zeroes them.
